// File: rtl/fifo_pkg.sv
// fifo_pkg: shared read-mode names and width helpers for the parametrised sync FIFO
package fifo_pkg;

    localparam string MODE_STD  = "STD";
    localparam string MODE_FWFT = "FWFT";

    // ceil(log2(n)) for n >= 1
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // bits needed for a level counter spanning 0..2**aw inclusive
    function automatic int lvl_w(input int aw);
        return clog2((1 << aw) + 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: simple dual-port RAM, one write port and one registered read port
module sync_fifo_ram #(
    parameter int DATA_WIDTH = 66,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

    // no reset on array or read register so the tools can map this onto block RAM
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_wl.sv
// sync_fifo_wl: single-clock FIFO with STD/FWFT read, water level, almost flags and flush
module sync_fifo_wl
    import fifo_pkg::*;
#(
    parameter int                    DATA_WIDTH       = 66,
    parameter int                    ADDR_WIDTH       = 9,
    parameter string                 READ_MODE        = "STD",
    parameter int                    ALMOST_FULL_NUM  = 500,
    parameter int                    ALMOST_EMPTY_NUM = 4,
    parameter logic [DATA_WIDTH-1:0] RST_VAL          = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  wr_full,
    output logic                  almost_full,
    output logic                  overflow,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  almost_empty,
    output logic                  underflow,
    output logic [ADDR_WIDTH:0]   water_level
);

    localparam int            DEPTH  = 1 << ADDR_WIDTH;
    localparam int            LW     = lvl_w(ADDR_WIDTH);
    localparam bit            FWFT   = READ_MODE == MODE_FWFT;
    localparam logic [LW-1:0] FULL_L = LW'(DEPTH);
    localparam logic [LW-1:0] AF_L   = LW'(ALMOST_FULL_NUM);
    localparam logic [LW-1:0] AE_L   = LW'(ALMOST_EMPTY_NUM);

    if (READ_MODE != MODE_STD && READ_MODE != MODE_FWFT) begin : g_bad_mode
        $error("sync_fifo_wl: READ_MODE must be \"STD\" or \"FWFT\"");
    end
    if (ADDR_WIDTH < 4 || ADDR_WIDTH > 20) begin : g_bad_aw
        $error("sync_fifo_wl: ADDR_WIDTH out of range 4..20");
    end
    if (ALMOST_FULL_NUM < 1 || ALMOST_FULL_NUM > DEPTH) begin : g_bad_af
        $error("sync_fifo_wl: ALMOST_FULL_NUM out of range 1..DEPTH");
    end
    if (ALMOST_EMPTY_NUM < 0 || ALMOST_EMPTY_NUM > DEPTH - 1) begin : g_bad_ae
        $error("sync_fifo_wl: ALMOST_EMPTY_NUM out of range 0..DEPTH-1");
    end

    logic [LW-1:0]         wptr, rptr, lvl_nx;
    logic                  wr_acc, rd_acc, fetch, empty_nx, valid_nx, rd_rst;
    logic [DATA_WIDTH-1:0] ram_q;

    // acceptance is judged on registered flags only, so a same-cycle read/write never rescues the other
    always_comb begin
        wr_acc = wr_en & ~wr_full;
        rd_acc = rd_en & ~rd_empty;
        lvl_nx = water_level + LW'(wr_acc) - LW'(rd_acc);
    end

    if (FWFT) begin : g_fwft
        // the RAM read register is the prefetch stage; refill it whenever it is empty or being popped
        assign fetch    = (wptr != rptr) & (rd_empty | rd_acc);
        assign empty_nx = ~fetch & (rd_empty | rd_acc);
        assign valid_nx = ~empty_nx;
    end else begin : g_std
        assign fetch    = rd_acc;
        assign empty_nx = lvl_nx == '0;
        assign valid_nx = rd_acc;
    end

    sync_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk  (clk),
        .we   (wr_acc & ~clr),
        .waddr(wptr[ADDR_WIDTH-1:0]),
        .wdata(wr_data),
        .re   (fetch & ~clr),
        .raddr(rptr[ADDR_WIDTH-1:0]),
        .rdata(ram_q)
    );

    // rd_rst masks the unreset RAM register until the first word is fetched after reset/flush
    assign rd_data = rd_rst ? RST_VAL : ram_q;

    // pointers, level and registered flags; clr acts as a synchronous reset with top priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {wptr, rptr, water_level} <= '0;
            {wr_full, almost_full, overflow, rd_valid, underflow} <= '0;
            {rd_empty, almost_empty, rd_rst} <= '1;
        end else if (clr) begin
            {wptr, rptr, water_level} <= '0;
            {wr_full, almost_full, overflow, rd_valid, underflow} <= '0;
            {rd_empty, almost_empty, rd_rst} <= '1;
        end else begin
            wptr         <= wptr + LW'(wr_acc);
            rptr         <= rptr + LW'(fetch);
            water_level  <= lvl_nx;
            wr_full      <= lvl_nx == FULL_L;
            almost_full  <= lvl_nx >= AF_L;
            almost_empty <= lvl_nx <= AE_L;
            rd_empty     <= empty_nx;
            rd_valid     <= valid_nx;
            overflow     <= wr_en & wr_full;
            underflow    <= rd_en & rd_empty;
            if (fetch) rd_rst <= 1'b0;
        end
    end

endmodule
